mode_counter: RTL and testbench

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/mode_counter.sv | 63 ++++++
 tb/tb_mode_counter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// mode_counter: up/down counter with wrap, saturate and one-shot modes.
// Define MODE_COUNTER_PRESCALER_EN to divide the count enable by PRESCALE.
module mode_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] dat_in,
  output logic [WIDTH-1:0] dat_out,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] dat_n, ld_val;
  logic tick, step, bnd, osh, sat, held, held_n, tc_n;
`ifdef MODE_COUNTER_PRESCALER_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pcnt;
  assign tick = en && pcnt == PW'(PRESCALE-1);
  always_ff @(posedge clk)
    if (rst || ld) pcnt <= '0;
    else if (en) pcnt <= tick ? '0 : pcnt + PW'(1);
`else
  localparam int unused_prescale = PRESCALE;
  assign tick = en;
`endif
  assign osh  = mode == 2'b10;
  assign sat  = mode == 2'b01;
  assign bnd  = dir ? dat_out == MAX : dat_out == '0;
  assign step = tick && !ld && (!osh || state == RUN);
  assign busy = state == RUN;
  assign done = state == DONE;
  // held suppresses repeat tc pulses while saturate keeps pinning the boundary
  always_comb begin
    ld_val  = dat_in > MAX ? MAX : dat_in;
    dat_n   = ld ? ld_val : !step ? dat_out : !bnd ? (dir ? dat_out + WIDTH'(1) : dat_out - WIDTH'(1)) :
              (sat || osh) ? dat_out : dir ? '0 : MAX;
    state_n = !osh ? IDLE : ld ? RUN : (step && bnd) ? DONE : state;
    tc_n    = step && bnd && !(sat && held);
    held_n  = sat && !ld && (step ? bnd : held);
  end
  always_ff @(posedge clk)
    if (rst) begin
      dat_out <= '0;
      tc      <= 1'b0;
      held    <= 1'b0;
      state   <= IDLE;
    end else begin
      dat_out <= dat_n;
      tc      <= tc_n;
      held    <= held_n;
      state   <= state_n;
    end
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed vector table plus randomized run against a reference model.
module tb_mode_counter;
  localparam int W = 4, MV = 9, PS = 4;
  logic clk = 1'b0, rst, en, ld, dir, tc, busy, done;
  logic [1:0] mode;
  logic [W-1:0] dat_in, dat_out;
  int vecs = 0, errs = 0;
  int m_val = 0, m_fsm = 0, m_pre = 0;
  bit m_tc = 0, m_stuck = 0;

  mode_counter #(.WIDTH(W), .MAX_VAL(MV), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .dir(dir), .mode(mode),
    .dat_in(dat_in), .dat_out(dat_out), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, e, l, d, md, din, q, t, b, dn;
  } vec_t;
  vec_t tbl[$];

  // Reference: fsm 0=idle 1=run 2=done; stuck marks a saturate hold already reported by tc
  task automatic model(input bit r, input bit e, input bit l, input bit d, input int md, input int din);
    bit go, at_end;
    if (r) begin
      m_val = 0; m_tc = 0; m_fsm = 0; m_stuck = 0; m_pre = 0;
      return;
    end
    go = e && !l;
`ifdef MODE_COUNTER_PRESCALER_EN
    go = go && m_pre == PS-1;
    if (l) m_pre = 0;
    else if (e) m_pre = (m_pre + 1) % PS;
`endif
    at_end = d ? m_val == MV : m_val == 0;
    m_tc = 0;
    if (l) begin
      m_val = din > MV ? MV : din;
      m_stuck = 0;
      m_fsm = md == 2 ? 1 : 0;
    end else if (md == 2) begin
      if (m_fsm == 1 && go) begin
        if (at_end) begin m_fsm = 2; m_tc = 1; end
        else m_val += d ? 1 : -1;
      end
    end else begin
      m_fsm = 0;
      if (go) begin
        if (!at_end) begin m_val += d ? 1 : -1; m_stuck = 0; end
        else if (md == 1) begin m_tc = !m_stuck; m_stuck = 1; end
        else begin m_val = d ? 0 : MV; m_tc = 1; end
      end
    end
    if (md != 1) m_stuck = 0;
  endtask

  task automatic drive(input int r, input int e, input int l, input int d, input int md, input int din);
    rst = r != 0; en = e != 0; ld = l != 0; dir = d != 0;
    mode = 2'(md); dat_in = W'(din);
    model(r != 0, e != 0, l != 0, d != 0, md, din);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [6:0] exp);
    logic [6:0] act;
    act = {dat_out, tc, busy, done};
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got dat=%0d tc=%b busy=%b done=%b, want dat=%0d tc=%b busy=%b done=%b",
               nm, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [6:0] mexp();
    return {W'(m_val), m_tc, m_fsm == 1, m_fsm == 2};
  endfunction

  task automatic row(input int r, input int e, input int l, input int d, input int md, input int din,
                     input int q, input int t, input int b, input int dn);
    vec_t v;
    v = '{r, e, l, d, md, din, q, t, b, dn};
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; dir = 1'b0; mode = 2'b00; dat_in = '0;
    drive(1, 0, 0, 0, 0, 0);
    check("reset", 7'b0);
`ifndef MODE_COUNTER_PRESCALER_EN
    //   r e l d md din   q t b dn
    row(1, 1, 1, 1, 0, 5,    0, 0, 0, 0);
    row(0, 0, 1, 1, 0, 7,    7, 0, 0, 0);
    row(0, 1, 0, 1, 0, 0,    8, 0, 0, 0);
    row(0, 1, 0, 1, 0, 0,    9, 0, 0, 0);
    row(0, 1, 0, 1, 0, 0,    0, 1, 0, 0);
    row(0, 1, 0, 1, 0, 0,    1, 0, 0, 0);
    row(0, 0, 1, 0, 1, 15,   9, 0, 0, 0);
    for (int k = 8; k >= 0; k--) row(0, 1, 0, 0, 1, 0, k, 0, 0, 0);
    row(0, 1, 0, 0, 1, 0,    0, 1, 0, 0);
    row(0, 1, 0, 0, 1, 0,    0, 0, 0, 0);
    row(0, 0, 0, 0, 1, 0,    0, 0, 0, 0);
    row(0, 1, 0, 1, 2, 0,    0, 0, 0, 0);
    row(0, 1, 1, 1, 2, 7,    7, 0, 1, 0);
    row(0, 1, 0, 1, 2, 0,    8, 0, 1, 0);
    row(0, 1, 0, 1, 2, 0,    9, 0, 1, 0);
    row(0, 1, 0, 1, 2, 0,    9, 1, 0, 1);
    row(0, 1, 0, 1, 2, 0,    9, 0, 0, 1);
    row(0, 1, 1, 1, 2, 2,    2, 0, 1, 0);
    row(0, 1, 1, 1, 2, 5,    5, 0, 1, 0);
    row(0, 1, 0, 1, 2, 0,    6, 0, 1, 0);
    row(1, 1, 0, 1, 2, 0,    0, 0, 0, 0);
    row(0, 1, 0, 1, 2, 0,    0, 0, 0, 0);
    row(0, 0, 1, 1, 2, 8,    8, 0, 1, 0);
    row(0, 0, 0, 1, 0, 0,    8, 0, 0, 0);
    row(0, 1, 0, 1, 2, 0,    8, 0, 0, 0);
    row(0, 0, 1, 0, 3, 0,    0, 0, 0, 0);
    row(0, 1, 0, 0, 3, 0,    9, 1, 0, 0);
    row(0, 1, 0, 1, 3, 0,    0, 1, 0, 0);
    row(0, 1, 0, 1, 3, 0,    1, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].d, tbl[i].md, tbl[i].din);
      check($sformatf("tbl[%0d]", i),
            {W'(tbl[i].q), tbl[i].t != 0, tbl[i].b != 0, tbl[i].dn != 0});
    end
`else
    drive(0, 0, 1, 1, 0, 0);
    check("pre_ld", 7'b0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 0, 1, 0, 0);
      check($sformatf("pre_run%0d", i), {W'((i + 1) / 4), 3'b000});
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, (i == 2 || i == 3) ? 0 : 1, 0, 1, 0, 0);
      check($sformatf("pre_gap%0d", i), {W'(i == 5 ? 4 : 3), 3'b000});
    end
`endif
    drive(1, 0, 0, 0, 0, 0);
    check("rand_rst", mexp());
    begin
      int md;
      md = 0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
        drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) != 0 ? (i / 40) % 2 : $urandom_range(0, 1), md, $urandom_range(0, 15));
        check($sformatf("rand%0d", i), mexp());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
